// File: rtl/player_arbiter.sv
// Two-player arbiter for a single game character: grants one pad at a time,
// forwards only the owner's buttons, and pulses char_reset on every release.

// Per-player release decision: whether the current owner gives up control.
module player_lane #(
    parameter int HOLD_CYCLES = 8,
    parameter int MAX_CYCLES  = 64,
    parameter int TW          = $clog2(MAX_CYCLES + 1)
) (
    input  logic          own,
    input  logic          req_self,
    input  logic          req_other,
    input  logic [2:0]    pad,
    input  logic [TW-1:0] tenure,
    output logic          yield
);
    localparam logic [TW-1:0] HOLD_T = TW'(HOLD_CYCLES);
    localparam logic [TW-1:0] MAX_T  = TW'(MAX_CYCLES);

    logic idle_pad;
    logic polite;
    logic forced;

    // A contested owner yields only between actions, unless tenure has maxed out.
    assign idle_pad = (pad == 3'b000);
    assign polite   = req_other && (tenure >= HOLD_T) && idle_pad;
    assign forced   = req_other && (tenure >= MAX_T);
    assign yield    = own && (!req_self || polite || forced);
endmodule

module player_arbiter #(
    parameter int HOLD_CYCLES = 8,
    parameter int MAX_CYCLES  = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       p0_req,
    input  logic [2:0] p0_buttons,
    input  logic       p1_req,
    input  logic [2:0] p1_buttons,
    output logic [1:0] grant,
    output logic [2:0] buttons,
    output logic       char_reset
);
    localparam int TW = $clog2(MAX_CYCLES + 1);
    localparam logic [TW-1:0] MAX_T = TW'(MAX_CYCLES);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OWN0     = 2'd1,
        OWN1     = 2'd2,
        HANDOVER = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [TW-1:0]   tenure, tenure_nxt;
    logic            last_owner, last_owner_nxt;
    logic [1:0]      grant_nxt;
    logic [2:0]      buttons_nxt;
    logic            char_reset_nxt;

    logic [1:0]      req;
    logic [1:0][2:0] pad;
    logic [1:0]      owns;
    logic [1:0]      yield;

    assign req     = {p1_req, p0_req};
    assign pad     = {p1_buttons, p0_buttons};
    assign owns[0] = (state == OWN0);
    assign owns[1] = (state == OWN1);

    for (genvar i = 0; i < 2; i++) begin : g_lane
        player_lane #(
            .HOLD_CYCLES(HOLD_CYCLES),
            .MAX_CYCLES (MAX_CYCLES),
            .TW         (TW)
        ) u_lane (
            .own      (owns[i]),
            .req_self (req[i]),
            .req_other(req[1-i]),
            .pad      (pad[i]),
            .tenure   (tenure),
            .yield    (yield[i])
        );
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (req[0] && req[1])
                    state_nxt = last_owner ? OWN0 : OWN1;
                else if (req[0])
                    state_nxt = OWN0;
                else if (req[1])
                    state_nxt = OWN1;
                else
                    state_nxt = IDLE;
            end
            OWN0:     if (yield[0]) state_nxt = HANDOVER;
            OWN1:     if (yield[1]) state_nxt = HANDOVER;
            // last_owner is the outgoing player here; only the other one may take over.
            HANDOVER: begin
                if (!last_owner)
                    state_nxt = req[1] ? OWN1 : IDLE;
                else
                    state_nxt = req[0] ? OWN0 : IDLE;
            end
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tenure_nxt     = '0;
        last_owner_nxt = last_owner;
        grant_nxt      = 2'b00;
        buttons_nxt    = 3'b000;
        char_reset_nxt = 1'b0;
        case (state_nxt)
            OWN0: begin
                grant_nxt   = 2'b01;
                buttons_nxt = p0_buttons;
                if (state == OWN0)
                    tenure_nxt = (tenure == MAX_T) ? tenure : tenure + 1'b1;
                else
                    last_owner_nxt = 1'b0;
            end
            OWN1: begin
                grant_nxt   = 2'b10;
                buttons_nxt = p1_buttons;
                if (state == OWN1)
                    tenure_nxt = (tenure == MAX_T) ? tenure : tenure + 1'b1;
                else
                    last_owner_nxt = 1'b1;
            end
            HANDOVER: char_reset_nxt = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            tenure     <= '0;
            last_owner <= 1'b1;
            grant      <= 2'b00;
            buttons    <= 3'b000;
            char_reset <= 1'b0;
        end else begin
            state      <= state_nxt;
            tenure     <= tenure_nxt;
            last_owner <= last_owner_nxt;
            grant      <= grant_nxt;
            buttons    <= buttons_nxt;
            char_reset <= char_reset_nxt;
        end
    end
endmodule

// File: tb/tb_player_arbiter.sv
// Directed bench for player_arbiter: each step drives pads, queues the expected
// {grant, buttons, char_reset}, and checks it one edge later.
module tb_player_arbiter;
    logic       clk;
    logic       reset;
    logic       p0_req;
    logic [2:0] p0_buttons;
    logic       p1_req;
    logic [2:0] p1_buttons;
    logic [1:0] grant;
    logic [2:0] buttons;
    logic       char_reset;

    logic [5:0] exp_q[$];
    string      tag_q[$];
    int         total;
    int         bad;

    player_arbiter #(.HOLD_CYCLES(8), .MAX_CYCLES(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .p0_req    (p0_req),
        .p0_buttons(p0_buttons),
        .p1_req    (p1_req),
        .p1_buttons(p1_buttons),
        .grant     (grant),
        .buttons   (buttons),
        .char_reset(char_reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_out(input string tag, input logic [1:0] g,
                              input logic [2:0] b, input logic cr);
        exp_q.push_back({g, b, cr});
        tag_q.push_back(tag);
    endtask

    task automatic check_out();
        logic [5:0] e;
        logic [5:0] obs;
        string      t;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty obs=none exp=entry");
        end else begin
            e   = exp_q.pop_front();
            t   = tag_q.pop_front();
            obs = {grant, buttons, char_reset};
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s grant/buttons/char_reset obs=%b_%b_%b exp=%b_%b_%b",
                       t, obs[5:4], obs[3:1], obs[0], e[5:4], e[3:1], e[0]);
            end
        end
    endtask

    task automatic step(input string tag,
                        input logic r0, input logic [2:0] b0,
                        input logic r1, input logic [2:0] b1,
                        input logic [1:0] g, input logic [2:0] b, input logic cr);
        @(negedge clk);
        p0_req     = r0;
        p0_buttons = b0;
        p1_req     = r1;
        p1_buttons = b1;
        expect_out(tag, g, b, cr);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        reset      = 1'b0;
        p0_req     = 1'b0;
        p0_buttons = 3'b000;
        p1_req     = 1'b0;
        p1_buttons = 3'b000;

        #3;
        expect_out("reset_state", 2'b00, 3'b000, 1'b0);
        check_out();
        @(negedge clk);
        reset = 1'b1;

        // p0 alone wins in one edge; p1's pad never leaks.
        step("p0_grant",     1, 3'b100, 0, 3'b011, 2'b01, 3'b100, 0);
        step("p0_hold",      1, 3'b100, 0, 3'b011, 2'b01, 3'b100, 0);
        step("p0_btn_track", 1, 3'b001, 0, 3'b111, 2'b01, 3'b001, 0);
        step("p0_release",   0, 3'b001, 0, 3'b111, 2'b00, 3'b000, 1);
        step("idle_after",   0, 3'b000, 0, 3'b000, 2'b00, 3'b000, 0);

        // Asynchronous reset while p1 owns: outputs clear before any edge.
        step("p1_grant",     0, 3'b000, 1, 3'b010, 2'b10, 3'b010, 0);
        #2;
        reset = 1'b0;
        #1;
        expect_out("async_reset", 2'b00, 3'b000, 1'b0);
        check_out();
        p1_req     = 1'b0;
        p1_buttons = 3'b000;
        @(posedge clk);
        #1;
        expect_out("reset_no_pulse", 2'b00, 3'b000, 1'b0);
        check_out();
        @(negedge clk);
        reset = 1'b1;

        // First tie after reset goes to p0; p0 drops at tenure 3.
        step("tie_p0_wins",  1, 3'b000, 1, 3'b000, 2'b01, 3'b000, 0);
        step("tie_t1",       1, 3'b000, 1, 3'b000, 2'b01, 3'b000, 0);
        step("tie_t2",       1, 3'b000, 1, 3'b000, 2'b01, 3'b000, 0);
        step("tie_t3",       1, 3'b000, 1, 3'b000, 2'b01, 3'b000, 0);
        step("drop_handover",0, 3'b000, 1, 3'b001, 2'b00, 3'b000, 1);
        step("p1_takes",     0, 3'b111, 1, 3'b001, 2'b10, 3'b001, 0);
        step("p1_no_p0_pad", 0, 3'b111, 1, 3'b110, 2'b10, 3'b110, 0);
        step("p1_release",   0, 3'b000, 0, 3'b000, 2'b00, 3'b000, 1);
        step("idle_2",       0, 3'b000, 0, 3'b000, 2'b00, 3'b000, 0);

        // Polite preemption: waits for tenure 8 with an idle owner pad.
        step("hold_grant",   1, 3'b000, 0, 3'b000, 2'b01, 3'b000, 0);
        step("hold_t0",      1, 3'b000, 0, 3'b000, 2'b01, 3'b000, 0);
        step("hold_t1",      1, 3'b000, 0, 3'b000, 2'b01, 3'b000, 0);
        for (int t = 2; t < 8; t++)
            step("hold_wait",1, 3'b000, 1, 3'b000, 2'b01, 3'b000, 0);
        step("hold_t8_yield",1, 3'b000, 1, 3'b000, 2'b00, 3'b000, 1);
        step("hold_p1",      1, 3'b000, 1, 3'b101, 2'b10, 3'b101, 0);
        step("hold_p1_rel",  0, 3'b000, 0, 3'b000, 2'b00, 3'b000, 1);
        step("idle_3",       0, 3'b000, 0, 3'b000, 2'b00, 3'b000, 0);

        // Busy owner is only forced out at tenure 64.
        step("max_grant",    1, 3'b010, 0, 3'b000, 2'b01, 3'b010, 0);
        for (int t = 0; t < 64; t++)
            step("max_busy", 1, 3'b010, 1, 3'b000, 2'b01, 3'b010, 0);
        step("max_forced",   1, 3'b010, 1, 3'b000, 2'b00, 3'b000, 1);
        step("max_p1",       1, 3'b010, 1, 3'b011, 2'b10, 3'b011, 0);

        // p1 releases into p0, then p1 drops during the next handover.
        step("p1_drop",      1, 3'b000, 0, 3'b000, 2'b00, 3'b000, 1);
        step("p0_from_ho",   1, 3'b100, 0, 3'b000, 2'b01, 3'b100, 0);
        step("p0_leave",     0, 3'b000, 1, 3'b000, 2'b00, 3'b000, 1);
        step("ho_to_idle",   1, 3'b000, 0, 3'b000, 2'b00, 3'b000, 0);
        step("p0_regrant",   1, 3'b001, 0, 3'b000, 2'b01, 3'b001, 0);
        step("p0_rel_2",     0, 3'b000, 0, 3'b000, 2'b00, 3'b000, 1);
        step("idle_4",       0, 3'b000, 0, 3'b000, 2'b00, 3'b000, 0);

        // last_owner is p0 now, so a tie goes to p1.
        step("tie_p1_wins",  1, 3'b111, 1, 3'b010, 2'b10, 3'b010, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/player_arbiter.md
PLAYER_ARBITER -- requirements
Module: player_arbiter

Interface
REQ-001 Parameter HOLD_CYCLES, default 8: minimum ownership tenure before voluntary preemption.
REQ-002 Parameter MAX_CYCLES, default 64: tenure at which preemption is forced, with MAX_CYCLES > HOLD_CYCLES >= 1.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset; logic 0 resets the block.
REQ-005 p0_req  in  1  player 0 requests control of the character.
REQ-006 p0_buttons  in  3  player 0 pad, bit 2 = X, bit 1 = Y, bit 0 = B.
REQ-007 p1_req  in  1  player 1 requests control of the character.
REQ-008 p1_buttons  in  3  player 1 pad, same bit map as p0_buttons.
REQ-009 grant  out  2  one-hot owner: 01 = player 0, 10 = player 1, 00 = none.
REQ-010 buttons  out  3  button vector forwarded to the character FSM's buttons input.
REQ-011 char_reset  out  1  one-cycle active-high pulse to the character FSM's reset input on every ownership release.

Function
REQ-012 The states SHALL be IDLE, OWN0, OWN1 and HANDOVER; grant, buttons and char_reset SHALL be registered.
REQ-013 In IDLE with exactly one req high, the next state SHALL be OWN of that player.
REQ-014 In IDLE with both req high, the grant SHALL go to the player other than last_owner; last_owner resets to player 1, so player 0 wins the first tie.
REQ-015 In IDLE with no req high, the block SHALL stay in IDLE.
REQ-016 On entering OWNx, the tenure counter SHALL clear to 0 and last_owner SHALL become x.
REQ-017 In OWNx, tenure SHALL increment by 1 per cycle and saturate at MAX_CYCLES.
REQ-018 The tenure counter SHALL be $clog2(MAX_CYCLES+1) bits wide.
REQ-019 OWNx SHALL go to HANDOVER when px_req = 0.
REQ-020 OWNx SHALL go to HANDOVER when the other req = 1, tenure >= HOLD_CYCLES and px_buttons = 000, so an owner is never cut mid-action.
REQ-021 OWNx SHALL go to HANDOVER when the other req = 1 and tenure >= MAX_CYCLES, regardless of px_buttons.
REQ-022 Otherwise, OWNx SHALL stay in OWNx.
REQ-023 HANDOVER SHALL last exactly one cycle with grant = 00, buttons = 000 and char_reset = 1.
REQ-024 HANDOVER SHALL exit to OWN of the non-outgoing player if that player's req = 1, else to IDLE; the outgoing player is not eligible in that cycle.
REQ-025 Outputs SHALL be loaded at the edge that enters each state: grant matches the next state, and buttons = owner's buttons sampled at that edge if the next state is OWNx, else 000.
REQ-026 Request-to-grant latency SHALL be one clock edge; the non-owner's buttons SHALL never reach the buttons output.
REQ-027 char_reset SHALL be 1 only in HANDOVER cycles.
REQ-028 X-free inputs are required; an illegal state encoding SHALL recover to IDLE on the next edge.

Reset
REQ-029 While reset = 0, the block SHALL asynchronously force state = IDLE, grant = 00, buttons = 000, char_reset = 0, tenure = 0 and last_owner = player 1.
REQ-030 Reset asserted mid-OWN or mid-HANDOVER SHALL abort without a char_reset pulse.
REQ-031 The first edge after reset release SHALL evaluate IDLE normally.

Verification
REQ-032 Reset during OWN1 with buttons = 010 -> grant = 00 and buttons = 000 immediately, before any clock edge; char_reset stays 0.
REQ-033 p0_req = 1 with p0_buttons = 100 and p1_buttons = 011 -> after one edge grant = 01 and buttons = 100; p1 pad never appears on buttons.
REQ-034 Both req asserted after reset, then p0_req dropped at tenure 3 -> grant sequence 01, then 00 with char_reset = 1 for one cycle, then 10.
REQ-035 p0 owns, p1_req rises at tenure 2 with p0_buttons = 000 -> HANDOVER entered only after tenure reaches 8; grant = 01 holds until then.
REQ-036 p0 owns with p0_buttons held at 010 and p1_req = 1 -> no handover before tenure 64; at tenure 64, HANDOVER then grant = 10.
REQ-037 p1_req drops during a HANDOVER from OWN0 while p0_req = 1 -> HANDOVER goes to IDLE, then grant = 01 after the next edge.
